simple_adapter_arb: RTL and testbench
=====================================

SIMPLE_ADAPTER_ARB -- requirements
Module: simple_adapter_arb

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of packet sources, 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, beat width fed to the width-up adapter chain.
REQ-003 SHALL have parameter TAG_DEPTH, default 4, packets in flight through the adapter, power of 2, >= 2.
REQ-004 SHALL have ports in this order:
- clk  in  1  single clock for all logic.
- rst  in  1  reset, asynchronous, active-high.
- s_vld  in  NUM_SRC  per-source beat valid.
- s_last  in  NUM_SRC  per-source last beat of packet.
- s_data  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_rdy  out  NUM_SRC  per-source beat accept.
- ad_vld  out  1  to adapter din_vld.
- ad_last  out  1  to adapter din_last.
- ad_data  out  DATA_WIDTH  to adapter din.
- ad_out_vld  in  1  adapter dout_vld, monitored.
- ad_out_last  in  1  adapter dout_last, monitored.
- tag_id  out  $clog2(NUM_SRC)  source of the packet currently leaving the adapter.
- tag_vld  out  1  tag_id valid, tag FIFO not empty.
- busy  out  1  a packet is granted.
- tag_err  out  1  sticky, adapter emitted a last beat with no tag queued.

Function
REQ-005 SHALL share one adapter chain between NUM_SRC sources using packet-granular round-robin arbitration.
REQ-006 SHALL implement two states: IDLE and XFER.
REQ-007 In IDLE, if any s_vld is set and the tag FIFO is not full, SHALL grant the first requester at or after (ptr+1) mod NUM_SRC, then enter XFER on the next edge.
REQ-008 SHALL register the grant index g.
REQ-009 SHALL push g into the tag FIFO on the IDLE->XFER transition.
REQ-010 In IDLE with no requests or with a full tag FIFO, SHALL stay in IDLE with all s_rdy low.
REQ-011 In XFER, SHALL drive s_rdy[g]=1 combinationally and every other s_rdy bit to 0.
REQ-012 A beat SHALL transfer when s_vld[g] & s_rdy[g] are both set.
REQ-013 In XFER, a transfer with s_last[g]=1 SHALL return the block to IDLE and set ptr<=g.
REQ-014 Each grant SHALL add exactly one IDLE bubble cycle between packets.
REQ-015 ad_vld, ad_last and ad_data SHALL be registered copies of the transferred beat, one cycle latency.
REQ-016 When no beat transfers, ad_vld SHALL be 0, ad_last SHALL be 0, and ad_data SHALL hold its previous value.
REQ-017 While s_vld[g]=0 in XFER, SHALL remain in XFER without timeout; ungranted sources SHALL wait.
REQ-018 busy SHALL be 1 exactly while in XFER.
REQ-019 The tag FIFO SHALL be TAG_DEPTH entries with wrapping read/write pointers and a count of width $clog2(TAG_DEPTH)+1.
REQ-020 The tag FIFO SHALL pop on ad_out_vld & ad_out_last when not empty.
REQ-021 tag_id SHALL be the FIFO head and tag_vld SHALL be (count != 0), both combinational from registers.
REQ-022 On a pop with an empty FIFO, SHALL set tag_err=1 until reset and leave the pointers unchanged.
REQ-023 When the FIFO is full, a grant SHALL be blocked even if a pop occurs in the same cycle; the pop frees the slot for the next cycle.
REQ-024 A push and a pop in the same cycle with the FIFO non-empty SHALL leave count unchanged and advance both pointers.
REQ-025 A single-beat packet (s_vld & s_last on the first XFER cycle) SHALL be legal, giving 2 cycles per packet.

Reset
REQ-026 While rst=1, asynchronously: state=IDLE, ptr=NUM_SRC-1 (so source 0 has first priority), g=0, FIFO pointers and count=0.
REQ-027 While rst=1, all outputs SHALL be 0: s_rdy, ad_vld, ad_last, ad_data, tag_id, tag_vld, busy, tag_err.
REQ-028 Reset mid-packet SHALL abandon the packet with no ad_last emitted; the source is re-arbitrated from IDLE after rst falls.
REQ-029 The first grant after rst deassertion SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-030 Sources 0 and 2 each hold a 3-beat packet -> grant 0 first; ad_vld for 3 cycles with ad_last on the 3rd; 1 bubble; then source 2; tag FIFO holds 0,2.
REQ-031 All 4 sources request continuously with 1-beat packets -> grant order 0,1,2,3,0; each s_rdy is high 1 cycle in every 8.
REQ-032 TAG_DEPTH=4, no adapter pops, 5 queued packets -> 4 grants, then IDLE with busy=0; one ad_out_vld&ad_out_last pulse -> the 5th is granted on the following cycle.
REQ-033 ad_out_vld & ad_out_last pulsed with the FIFO empty -> tag_err=1 and held; count remains 0.
REQ-034 rst asserted after beat 2 of a 4-beat packet from source 1 -> all outputs 0 immediately; after release source 0 wins over source 1 when both request.
REQ-035 Source 3 granted with s_vld[3] dropped for 5 cycles mid-packet while source 0 requests -> s_rdy[0] stays 0 and ad_vld=0 during the gap; the packet completes, then source 0 is granted.

Source files
------------

// File: rtl/simple_adapter_arb.sv
// Packet-granular round-robin arbiter feeding one shared width-up adapter chain,
// with a tag FIFO that tracks which source owns each packet leaving the adapter.
// state | meaning:  IDLE | arbitrating / bubble between packets,  XFER | streaming granted source g
module simple_adapter_arb #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0]              s_vld,
  input  logic [NUM_SRC-1:0]              s_last,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_data,
  output logic [NUM_SRC-1:0]              s_rdy,
  output logic                            ad_vld,
  output logic                            ad_last,
  output logic [DATA_WIDTH-1:0]           ad_data,
  input  logic                            ad_out_vld,
  input  logic                            ad_out_last,
  output logic [$clog2(NUM_SRC)-1:0]      tag_id,
  output logic                            tag_vld,
  output logic                            busy,
  output logic                            tag_err
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t                 state_q;
  logic [IW-1:0]          ptr_q;
  logic [IW-1:0]          g_q;
  logic [IW-1:0]          tag_mem_q [TAG_DEPTH];
  logic [PW-1:0]          wr_q;
  logic [PW-1:0]          rd_q;
  logic [CW-1:0]          cnt_q;
  logic                   tag_err_q;
  logic                   ad_vld_q;
  logic                   ad_last_q;
  logic [DATA_WIDTH-1:0]  ad_data_q;

  logic                   gnt_found;
  logic [IW-1:0]          gnt_idx;
  logic [IW-1:0]          idx_c;
  int                     cand;
  logic                   full;
  logic                   grant;
  logic                   fire;
  logic                   pop_req;
  logic                   pop;

  // Search starts one past the last winner, so priority rotates per packet.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    idx_c     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand  = (int'(ptr_q) + 1 + k) % NUM_SRC;
      idx_c = IW'(cand);
      if (!gnt_found && s_vld[idx_c]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_c;
      end
    end
  end

  // Full is judged on the registered count: a same-cycle pop does not unblock a grant.
  assign full    = (cnt_q == CW'(TAG_DEPTH));
  assign grant   = (state_q == IDLE) && gnt_found && !full;
  assign fire    = (state_q == XFER) && s_vld[g_q];
  assign pop_req = ad_out_vld & ad_out_last;
  assign pop     = pop_req && (cnt_q != '0);

  always_comb begin
    s_rdy = '0;
    if (state_q == XFER) s_rdy[g_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(NUM_SRC - 1);
      g_q       <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      tag_err_q <= 1'b0;
      ad_vld_q  <= 1'b0;
      ad_last_q <= 1'b0;
      ad_data_q <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
    end else begin
      ad_vld_q  <= fire;
      ad_last_q <= fire & s_last[g_q];
      if (fire) ad_data_q <= s_data[g_q*DATA_WIDTH +: DATA_WIDTH];

      case (state_q)
        IDLE: begin
          if (grant) begin
            g_q     <= gnt_idx;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (fire && s_last[g_q]) begin
            ptr_q   <= g_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (grant) begin
        tag_mem_q[wr_q] <= gnt_idx;
        wr_q            <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (pop_req && (cnt_q == '0)) tag_err_q <= 1'b1;

      case ({grant, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign ad_vld  = ad_vld_q;
  assign ad_last = ad_last_q;
  assign ad_data = ad_data_q;
  assign tag_id  = tag_mem_q[rd_q];
  assign tag_vld = (cnt_q != '0);
  assign busy    = (state_q == XFER);
  assign tag_err = tag_err_q;

endmodule

// File: tb/tb_simple_adapter_arb.sv
// Bench for simple_adapter_arb: directed scenarios plus a random phase, all checked
// each cycle against a transaction-level model built from queues and integers.
module tb_simple_adapter_arb;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TD = 4;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    s_vld = '0;
  logic [N-1:0]    s_last = '0;
  logic [N*DW-1:0] s_data = '0;
  logic [N-1:0]    s_rdy;
  logic            ad_vld, ad_last;
  logic [DW-1:0]   ad_data;
  logic            ad_out_vld = 1'b0;
  logic            ad_out_last = 1'b0;
  logic [IW-1:0]   tag_id;
  logic            tag_vld, busy, tag_err;

  simple_adapter_arb #(.NUM_SRC(N), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_last(s_last), .s_data(s_data),
    .s_rdy(s_rdy), .ad_vld(ad_vld), .ad_last(ad_last), .ad_data(ad_data),
    .ad_out_vld(ad_out_vld), .ad_out_last(ad_out_last), .tag_id(tag_id),
    .tag_vld(tag_vld), .busy(busy), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // reference model state
  bit            m_busy;
  int            m_g, m_ptr;
  int            tagq[$];
  bit            m_err, m_adv, m_adl;
  logic [DW-1:0] m_add;

  // stimulus state
  int rem[N], hold[N], auto_len[N];
  bit auto_pop, pop_now, noise_en;
  int glog[$];
  bit prev_busy;
  bit obs_vld, obs_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_ptr = N - 1;
    tagq.delete();
    m_err = 0; m_adv = 0; m_adl = 0; m_add = '0;
    prev_busy = 0;
    glog.delete();
  endtask

  task automatic clr_stim();
    for (int i = 0; i < N; i++) begin rem[i] = 0; hold[i] = 0; auto_len[i] = 0; end
    auto_pop = 0; pop_now = 0; noise_en = 0;
  endtask

  task automatic check_outputs();
    logic [31:0] exp_rdy;
    exp_rdy = m_busy ? (32'd1 << m_g) : 32'd0;
    chk("s_rdy", s_rdy, exp_rdy);
    chk("busy", busy, m_busy);
    chk("tag_vld", tag_vld, tagq.size() != 0);
    if (tagq.size() != 0) chk("tag_id", tag_id, tagq[0]);
    chk("tag_err", tag_err, m_err);
    chk("ad_vld", ad_vld, m_adv);
    chk("ad_last", ad_last, m_adl);
    chk("ad_data", ad_data, m_add);
    obs_vld = ad_vld;
    obs_last = ad_last;
    if (busy && !prev_busy)
      for (int i = 0; i < N; i++) if (s_rdy[i]) glog.push_back(i);
    prev_busy = busy;
  endtask

  // Effect of the coming rising edge, phrased from the arbitration rules.
  task automatic model_step();
    bit full, was_empty, found;
    int c;
    full = (tagq.size() == TD);
    was_empty = (tagq.size() == 0);
    m_adv = 0; m_adl = 0;
    if (m_busy) begin
      if (s_vld[m_g]) begin
        m_adv = 1;
        m_adl = s_last[m_g];
        m_add = s_data[m_g*DW +: DW];
        rem[m_g]--;
        if (s_last[m_g]) begin m_busy = 0; m_ptr = m_g; end
      end
    end else if (s_vld != 0 && !full) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && s_vld[c]) begin found = 1; m_g = c; end
      end
      m_busy = 1;
      tagq.push_back(m_g);
    end
    if (ad_out_vld && ad_out_last) begin
      if (was_empty) m_err = 1;
      else void'(tagq.pop_front());
    end
  endtask

  task automatic step_now();
    int r;
    for (int i = 0; i < N; i++) begin
      if (rem[i] == 0 && auto_len[i] > 0) rem[i] = auto_len[i];
      s_vld[i]  = (rem[i] > 0) && (hold[i] == 0);
      s_last[i] = (rem[i] == 1);
      s_data[i*DW +: DW] = DW'($urandom);
    end
    ad_out_last = pop_now || (auto_pop && tagq.size() != 0);
    ad_out_vld  = ad_out_last;
    if (noise_en && !ad_out_last) begin
      r = $urandom_range(0, 7);
      if (r == 0) ad_out_vld = 1'b1;
      else if (r == 1) ad_out_last = 1'b1;
    end
    #1;
    check_outputs();
    model_step();
    for (int i = 0; i < N; i++) if (hold[i] > 0) hold[i]--;
    pop_now = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    step_now();
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_s_rdy", s_rdy, 0);
    chk("rst_ad_vld", ad_vld, 0);
    chk("rst_ad_last", ad_last, 0);
    chk("rst_ad_data", ad_data, 0);
    chk("rst_tag_id", tag_id, 0);
    chk("rst_tag_vld", tag_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tag_err", tag_err, 0);
    @(posedge clk); #1;
    chk("rst_edge_busy", busy, 0);
    chk("rst_edge_s_rdy", s_rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step_now();
  endtask

  initial begin
    logic [9:0] vseq, lseq;
    int cnt0;
    int exp_b[5];
    exp_b = '{0, 1, 2, 3, 0};

    // Two 3-beat packets from sources 0 and 2
    clr_stim();
    apply_reset();
    rem[0] = 3; rem[2] = 3;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      vseq[k-1] = obs_vld;
      lseq[k-1] = obs_last;
    end
    chk("A_vld_seq", vseq, 10'b0111011100);
    chk("A_last_seq", lseq, 10'b0100010000);
    chk("A_order0", glog.size() > 0 ? glog[0] : -1, 0);
    chk("A_order1", glog.size() > 1 ? glog[1] : -1, 2);
    chk("A_head0", tag_id, 0);
    pop_now = 1; cycle(); cycle();
    chk("A_head2", tag_id, 2);
    chk("A_vld2", tag_vld, 1);
    pop_now = 1; cycle(); cycle();
    chk("A_empty", tag_vld, 0);

    // All sources, continuous single-beat packets
    clr_stim();
    apply_reset();
    for (int i = 0; i < N; i++) auto_len[i] = 1;
    auto_pop = 1;
    cnt0 = 0;
    for (int k = 1; k <= 17; k++) begin
      cycle();
      if (k >= 2 && s_rdy[0]) cnt0++;
    end
    for (int i = 0; i < 5; i++) chk("B_order", glog.size() > i ? glog[i] : -1, exp_b[i]);
    chk("B_rdy0_per16", cnt0, 2);

    // Tag FIFO full blocks the fifth grant
    clr_stim();
    apply_reset();
    for (int i = 0; i < N; i++) rem[i] = 1;
    repeat (10) cycle();
    rem[2] = 1;
    repeat (4) cycle();
    chk("C_stall_busy", busy, 0);
    chk("C_ngrants", glog.size(), 4);
    pop_now = 1; cycle();
    cycle();
    chk("C_blocked", busy, 0);
    cycle();
    chk("C_grant5", busy, 1);
    chk("C_src5", glog.size() > 4 ? glog[4] : -1, 2);

    // Pop with empty tag FIFO
    clr_stim();
    apply_reset();
    pop_now = 1; cycle(); cycle();
    chk("D_err", tag_err, 1);
    chk("D_cnt0", tag_vld, 0);
    repeat (3) cycle();
    chk("D_err_held", tag_err, 1);

    // Reset in the middle of a packet from source 1
    clr_stim();
    apply_reset();
    auto_pop = 1;
    rem[1] = 4;
    repeat (4) cycle();
    chk("E_busy", busy, 1);
    chk("E_rdy", s_rdy, 4'b0010);
    rem[1] = 4; rem[0] = 2;
    apply_reset();
    repeat (12) cycle();
    chk("E_first", glog.size() > 0 ? glog[0] : -1, 0);
    chk("E_second", glog.size() > 1 ? glog[1] : -1, 1);

    // Granted source 3 stalls for 5 cycles while source 0 waits
    clr_stim();
    apply_reset();
    auto_pop = 1;
    rem[3] = 4;
    repeat (2) cycle();
    hold[3] = 5; rem[0] = 2;
    for (int j = 0; j < 5; j++) begin
      cycle();
      chk("F_rdy_gap", s_rdy, 4'b1000);
      if (j > 0) chk("F_vld_gap", ad_vld, 0);
    end
    repeat (15) cycle();
    chk("F_first", glog.size() > 0 ? glog[0] : -1, 3);
    chk("F_second", glog.size() > 1 ? glog[1] : -1, 0);

    // Random traffic with one reset in the middle
    clr_stim();
    noise_en = 1;
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 5);
        if (hold[i] == 0 && $urandom_range(0, 9) == 0) hold[i] = $urandom_range(1, 3);
      end
      pop_now = (tagq.size() != 0) && ($urandom_range(0, 2) == 0);
      if (c == 1000) apply_reset();
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
